// File: rtl/riscv_ctrl_pkg.sv
// riscv_ctrl_pkg
//   Shared definitions for the RV32I control path: controller state
//   encoding, the opcode enum (also used by the single-cycle decoder),
//   ALU operation classes, immediate formats and datapath select codes.
//   It also holds the control-word struct that the multicycle controller
//   drives onto its ports.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_START, S_FETCH, S_DECODE, S_MEM_ADR, S_MEM_READ, S_MEM_WB,
    S_MEM_WRITE, S_EXEC_R, S_EXEC_I, S_UPPER, S_ALU_WB, S_BRANCH,
    S_JAL, S_JALR, S_LINK, S_TRAP
  } state_e;

  typedef enum logic [6:0] {
    OP_LOAD   = 7'b0000011,
    OP_I_ALU  = 7'b0010011,
    OP_AUIPC  = 7'b0010111,
    OP_STORE  = 7'b0100011,
    OP_R      = 7'b0110011,
    OP_LUI    = 7'b0110111,
    OP_BRANCH = 7'b1100011,
    OP_JALR   = 7'b1100111,
    OP_JAL    = 7'b1101111
  } opcode_e;

  // ALU operation classes
  localparam logic [2:0] ALU_FUNCT  = 3'b000;  // decoded from funct3/funct7
  localparam logic [2:0] ALU_ADD    = 3'b001;
  localparam logic [2:0] ALU_ADD_ST = 3'b010;  // store address add
  localparam logic [2:0] ALU_CMP    = 3'b011;  // branch compare
  localparam logic [2:0] ALU_AUIPC  = 3'b100;
  localparam logic [2:0] ALU_LUI    = 3'b101;
  localparam logic [2:0] ALU_JALR   = 3'b110;

  // Immediate formats
  localparam logic [2:0] IMM_I_ALU  = 3'b000;
  localparam logic [2:0] IMM_I_LOAD = 3'b001;
  localparam logic [2:0] IMM_U      = 3'b010;
  localparam logic [2:0] IMM_S      = 3'b011;
  localparam logic [2:0] IMM_BJ     = 3'b100;
  localparam logic [2:0] IMM_JALR   = 3'b101;

  // Datapath selects
  localparam logic [1:0] SRC_A_PC     = 2'b00;
  localparam logic [1:0] SRC_A_OLD_PC = 2'b01;
  localparam logic [1:0] SRC_A_RS1    = 2'b10;
  localparam logic [1:0] SRC_B_RS2    = 2'b00;
  localparam logic [1:0] SRC_B_IMM    = 2'b01;
  localparam logic [1:0] SRC_B_FOUR   = 2'b10;
  localparam logic [1:0] RES_ALUOUT   = 2'b00;
  localparam logic [1:0] RES_MEM      = 2'b01;
  localparam logic [1:0] RES_ALU      = 2'b10;
  localparam logic       ADR_PC       = 1'b0;
  localparam logic       ADR_ALUOUT   = 1'b1;

  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       mem_req;
    logic       mem_write;
    logic       reg_write;
    logic       adr_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] imm_src;
    logic [2:0] alu_op;
    logic [1:0] result_src;
    logic       instr_done;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/multicycle_controller.sv
// multicycle_controller
//   Moore control FSM for a multicycle RV32I datapath. It sequences each
//   instruction through fetch, decode and the class-specific execute and
//   writeback states, and retires with a one-cycle instr_done pulse.
//   Unknown opcodes park the FSM in TRAP, where only reset releases it.
// Ports
//   clk, rst_n       : clock, asynchronous active-low reset
//   op[6:0]          : opcode from the instruction register (valid from DECODE)
//   mem_ready        : memory completes the current access this cycle
//   branch_taken     : comparator result, used in BRANCH
//   pc_write/ir_write: PC load / IR + old-PC load strobes
//   mem_req/mem_write: memory request / store strobe
//   reg_write        : register file write strobe
//   adr_src          : memory address select (0 PC, 1 ALUOut)
//   alu_src_a/b      : ALU operand selects
//   imm_src, alu_op  : immediate format, ALU operation class
//   result_src       : result select (00 ALUOut, 01 mem data, 10 ALU direct)
//   instr_done       : retire pulse
//   illegal          : sticky unknown-opcode flag (TRAP)
module multicycle_controller
  import riscv_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic       mem_ready,
  input  logic       branch_taken,
  output logic       pc_write,
  output logic       ir_write,
  output logic       mem_req,
  output logic       mem_write,
  output logic       reg_write,
  output logic       adr_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] imm_src,
  output logic [2:0] alu_op,
  output logic [1:0] result_src,
  output logic       instr_done,
  output logic       illegal
);

  state_e r_state;
  // Opcode facts latched in DECODE so MEM_ADR/UPPER outputs stay a
  // function of registered state only.
  logic   r_is_store;
  logic   r_is_lui;
  ctrl_t  w_ctrl;

  // NOTE: state registers use non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_START;
      r_is_store <= 1'b0;
      r_is_lui   <= 1'b0;
    end else begin
      case (r_state)
        S_START:  r_state <= S_FETCH;
        S_FETCH:  if (mem_ready) r_state <= S_DECODE;
        S_DECODE: begin
          r_is_store <= (op == OP_STORE);
          r_is_lui   <= (op == OP_LUI);
          case (op)
            OP_LOAD, OP_STORE: r_state <= S_MEM_ADR;
            OP_R:              r_state <= S_EXEC_R;
            OP_I_ALU:          r_state <= S_EXEC_I;
            OP_LUI, OP_AUIPC:  r_state <= S_UPPER;
            OP_BRANCH:         r_state <= S_BRANCH;
            OP_JAL:            r_state <= S_JAL;
            OP_JALR:           r_state <= S_JALR;
            default:           r_state <= S_TRAP;
          endcase
        end
        S_MEM_ADR:   r_state <= r_is_store ? S_MEM_WRITE : S_MEM_READ;
        S_MEM_READ:  if (mem_ready) r_state <= S_MEM_WB;
        S_MEM_WRITE: if (mem_ready) r_state <= S_FETCH;
        S_EXEC_R, S_EXEC_I, S_UPPER:            r_state <= S_ALU_WB;
        S_MEM_WB, S_ALU_WB, S_BRANCH, S_LINK:   r_state <= S_FETCH;
        S_JAL, S_JALR:                          r_state <= S_LINK;
        S_TRAP:      r_state <= S_TRAP;
        default:     r_state <= S_START;
      endcase
    end
  end

  // NOTE: the all-zero default before the case keeps this block free of
  // inferred latches and gives every unused strobe/select a defined 0.
  always_comb begin
    w_ctrl = '0;
    case (r_state)
      S_FETCH: begin
        w_ctrl.mem_req    = 1'b1;
        w_ctrl.adr_src    = ADR_PC;
        w_ctrl.alu_src_a  = SRC_A_PC;
        w_ctrl.alu_src_b  = SRC_B_FOUR;
        w_ctrl.alu_op     = ALU_ADD;
        w_ctrl.result_src = RES_ALU;
        w_ctrl.ir_write   = mem_ready;
        w_ctrl.pc_write   = mem_ready;
      end
      S_DECODE: begin
        // Branch/JAL target into ALUOut ahead of dispatch
        w_ctrl.alu_src_a = SRC_A_OLD_PC;
        w_ctrl.alu_src_b = SRC_B_IMM;
        w_ctrl.imm_src   = IMM_BJ;
      end
      S_MEM_ADR: begin
        w_ctrl.alu_src_a = SRC_A_RS1;
        w_ctrl.alu_src_b = SRC_B_IMM;
        w_ctrl.imm_src   = r_is_store ? IMM_S : IMM_I_LOAD;
        w_ctrl.alu_op    = r_is_store ? ALU_ADD_ST : ALU_ADD;
      end
      S_MEM_READ: begin
        w_ctrl.mem_req = 1'b1;
        w_ctrl.adr_src = ADR_ALUOUT;
      end
      S_MEM_WRITE: begin
        w_ctrl.mem_req    = 1'b1;
        w_ctrl.adr_src    = ADR_ALUOUT;
        w_ctrl.mem_write  = 1'b1;
        w_ctrl.instr_done = mem_ready;
      end
      S_MEM_WB: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.result_src = RES_MEM;
        w_ctrl.instr_done = 1'b1;
      end
      S_EXEC_R: begin
        w_ctrl.alu_src_a = SRC_A_RS1;
        w_ctrl.alu_src_b = SRC_B_RS2;
        w_ctrl.alu_op    = ALU_FUNCT;
      end
      S_EXEC_I: begin
        w_ctrl.alu_src_a = SRC_A_RS1;
        w_ctrl.alu_src_b = SRC_B_IMM;
        w_ctrl.imm_src   = IMM_I_ALU;
        w_ctrl.alu_op    = ALU_FUNCT;
      end
      S_UPPER: begin
        w_ctrl.alu_src_a = SRC_A_OLD_PC;
        w_ctrl.alu_src_b = SRC_B_IMM;
        w_ctrl.imm_src   = IMM_U;
        w_ctrl.alu_op    = r_is_lui ? ALU_LUI : ALU_AUIPC;
      end
      S_ALU_WB: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.result_src = RES_ALUOUT;
        w_ctrl.instr_done = 1'b1;
      end
      S_BRANCH: begin
        // Target already sits in ALUOut from DECODE; the ALU compares here
        w_ctrl.alu_src_a  = SRC_A_RS1;
        w_ctrl.alu_src_b  = SRC_B_RS2;
        w_ctrl.alu_op     = ALU_CMP;
        w_ctrl.result_src = RES_ALUOUT;
        w_ctrl.pc_write   = branch_taken;
        w_ctrl.instr_done = 1'b1;
      end
      S_JAL: begin
        w_ctrl.pc_write   = 1'b1;
        w_ctrl.result_src = RES_ALUOUT;
      end
      S_JALR: begin
        w_ctrl.alu_src_a  = SRC_A_RS1;
        w_ctrl.alu_src_b  = SRC_B_IMM;
        w_ctrl.imm_src    = IMM_JALR;
        w_ctrl.alu_op     = ALU_JALR;
        w_ctrl.result_src = RES_ALU;
        w_ctrl.pc_write   = 1'b1;
      end
      S_LINK: begin
        // rd <= old PC + 4
        w_ctrl.alu_src_a  = SRC_A_OLD_PC;
        w_ctrl.alu_src_b  = SRC_B_FOUR;
        w_ctrl.alu_op     = ALU_ADD;
        w_ctrl.result_src = RES_ALU;
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.instr_done = 1'b1;
      end
      S_TRAP:  w_ctrl.illegal = 1'b1;
      default: w_ctrl = '0;
    endcase
  end

  assign pc_write   = w_ctrl.pc_write;
  assign ir_write   = w_ctrl.ir_write;
  assign mem_req    = w_ctrl.mem_req;
  assign mem_write  = w_ctrl.mem_write;
  assign reg_write  = w_ctrl.reg_write;
  assign adr_src    = w_ctrl.adr_src;
  assign alu_src_a  = w_ctrl.alu_src_a;
  assign alu_src_b  = w_ctrl.alu_src_b;
  assign imm_src    = w_ctrl.imm_src;
  assign alu_op     = w_ctrl.alu_op;
  assign result_src = w_ctrl.result_src;
  assign instr_done = w_ctrl.instr_done;
  assign illegal    = w_ctrl.illegal;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller
//   Drives instruction opcodes and memory handshakes into the controller
//   and compares the full control word each cycle against a per-instruction
//   expected trace built from the controller's documented behaviour.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] op = 7'd0;
  logic       mem_ready = 1'b0;
  logic       branch_taken = 1'b0;
  logic       pc_write, ir_write, mem_req, mem_write, reg_write, adr_src;
  logic [1:0] alu_src_a, alu_src_b, result_src;
  logic [2:0] imm_src, alu_op;
  logic       instr_done, illegal;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
    .branch_taken(branch_taken), .pc_write(pc_write), .ir_write(ir_write),
    .mem_req(mem_req), .mem_write(mem_write), .reg_write(reg_write),
    .adr_src(adr_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .imm_src(imm_src), .alu_op(alu_op), .result_src(result_src),
    .instr_done(instr_done), .illegal(illegal)
  );

  typedef struct packed {
    logic       pc_write, ir_write, mem_req, mem_write, reg_write, adr_src;
    logic [1:0] alu_src_a, alu_src_b;
    logic [2:0] imm_src, alu_op;
    logic [1:0] result_src;
    logic       instr_done, illegal;
  } outs_t;

  typedef struct {
    outs_t exp;
    logic  rdy;
    logic  bt;
  } step_t;

  localparam logic [6:0] LOAD = 7'b0000011, STORE = 7'b0100011,
                         RTYP = 7'b0110011, IALU = 7'b0010011,
                         LUI = 7'b0110111, AUIPC = 7'b0010111,
                         BR = 7'b1100011, JAL = 7'b1101111,
                         JALR = 7'b1100111, BAD = 7'b1111111;

  logic [6:0] legal_ops [9] = '{LOAD, STORE, RTYP, IALU, LUI, AUIPC, BR, JAL, JALR};

  outs_t obs;
  assign obs = {pc_write, ir_write, mem_req, mem_write, reg_write, adr_src,
                alu_src_a, alu_src_b, imm_src, alu_op, result_src,
                instr_done, illegal};

  step_t trace[$];
  int    exp_lat;

  function automatic logic rnd();
    return 1'($urandom_range(1, 0));
  endfunction

  function automatic outs_t fetch_o(logic go);
    outs_t o = '0;
    o.mem_req = 1'b1; o.alu_src_b = 2'b10; o.alu_op = 3'b001;
    o.result_src = 2'b10; o.pc_write = go; o.ir_write = go;
    return o;
  endfunction

  function automatic outs_t alu_wb_o();
    outs_t o = '0;
    o.reg_write = 1'b1; o.instr_done = 1'b1;
    return o;
  endfunction

  function automatic outs_t link_o();
    outs_t o = '0;
    o.alu_src_a = 2'b01; o.alu_src_b = 2'b10; o.alu_op = 3'b001;
    o.result_src = 2'b10; o.reg_write = 1'b1; o.instr_done = 1'b1;
    return o;
  endfunction

  // Reference model: the cycle-by-cycle control word expected for one
  // instruction, with fw fetch waits and mw data-memory waits, plus the
  // FETCH-to-retire latency implied by the instruction class.
  task automatic build_trace(input logic [6:0] opc, input int fw, input int mw,
                             input logic bt);
    outs_t o;
    logic  st;
    trace.delete();
    for (int i = 0; i < fw; i++) trace.push_back('{exp: fetch_o(1'b0), rdy: 1'b0, bt: rnd()});
    trace.push_back('{exp: fetch_o(1'b1), rdy: 1'b1, bt: rnd()});
    o = '0; o.alu_src_a = 2'b01; o.alu_src_b = 2'b01; o.imm_src = 3'b100;
    trace.push_back('{exp: o, rdy: rnd(), bt: rnd()});
    case (opc)
      LOAD, STORE: begin
        st = (opc == STORE);
        o = '0; o.alu_src_a = 2'b10; o.alu_src_b = 2'b01;
        o.imm_src = st ? 3'b011 : 3'b001; o.alu_op = st ? 3'b010 : 3'b001;
        trace.push_back('{exp: o, rdy: rnd(), bt: rnd()});
        o = '0; o.mem_req = 1'b1; o.adr_src = 1'b1; o.mem_write = st;
        for (int i = 0; i < mw; i++) trace.push_back('{exp: o, rdy: 1'b0, bt: rnd()});
        o.instr_done = st;
        trace.push_back('{exp: o, rdy: 1'b1, bt: rnd()});
        if (!st) begin
          o = '0; o.reg_write = 1'b1; o.result_src = 2'b01; o.instr_done = 1'b1;
          trace.push_back('{exp: o, rdy: rnd(), bt: rnd()});
        end
        exp_lat = (st ? 4 : 5) + fw + mw;
      end
      RTYP, IALU, LUI, AUIPC: begin
        o = '0;
        if (opc == RTYP) begin o.alu_src_a = 2'b10; o.alu_src_b = 2'b00; end
        else if (opc == IALU) begin o.alu_src_a = 2'b10; o.alu_src_b = 2'b01; end
        else begin
          o.alu_src_a = 2'b01; o.alu_src_b = 2'b01; o.imm_src = 3'b010;
          o.alu_op = (opc == LUI) ? 3'b101 : 3'b100;
        end
        trace.push_back('{exp: o, rdy: rnd(), bt: rnd()});
        trace.push_back('{exp: alu_wb_o(), rdy: rnd(), bt: rnd()});
        exp_lat = 4 + fw;
      end
      BR: begin
        o = '0; o.alu_src_a = 2'b10; o.alu_op = 3'b011; o.pc_write = bt;
        o.instr_done = 1'b1;
        trace.push_back('{exp: o, rdy: rnd(), bt: bt});
        exp_lat = 3 + fw;
      end
      JAL, JALR: begin
        o = '0; o.pc_write = 1'b1;
        if (opc == JALR) begin
          o.alu_src_a = 2'b10; o.alu_src_b = 2'b01; o.imm_src = 3'b101;
          o.alu_op = 3'b110; o.result_src = 2'b10;
        end
        trace.push_back('{exp: o, rdy: rnd(), bt: rnd()});
        trace.push_back('{exp: link_o(), rdy: rnd(), bt: rnd()});
        exp_lat = 4 + fw;
      end
      default: begin
        o = '0; o.illegal = 1'b1;
        for (int i = 0; i < 12; i++) trace.push_back('{exp: o, rdy: rnd(), bt: rnd()});
        exp_lat = -1;  // never retires
      end
    endcase
  endtask

  // Drive one cycle's inputs after the falling edge and sample mid-cycle
  task automatic drive_cycle(input logic rdy, input logic bt, output outs_t got);
    @(negedge clk);
    mem_ready = rdy;
    branch_taken = bt;
    #1;
    got = obs;
  endtask

  // Play one instruction, compare every cycle and the retire latency
  task automatic test_instr(input string name, input logic [6:0] opc,
                            input int fw, input int mw, input logic bt);
    outs_t got;
    int    lat_seen = -1;
    op = opc;
    build_trace(opc, fw, mw, bt);
    foreach (trace[k]) begin
      drive_cycle(trace[k].rdy, trace[k].bt, got);
      checks++;
      if (got !== trace[k].exp) begin
        errors++;
        $display("FAIL %s cycle %0d: control word got %h expected %h",
                 name, k, got, trace[k].exp);
      end
      if (got.instr_done === 1'b1 && lat_seen < 0) lat_seen = k + 1;
    end
    checks++;
    if (lat_seen != exp_lat) begin
      errors++;
      $display("FAIL %s latency: got %0d expected %0d", name, lat_seen, exp_lat);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    mem_ready = 1'b1;
    op = RTYP;
    @(negedge clk); #1;
    checks++;
    if (obs !== outs_t'(0)) begin
      errors++; $display("FAIL reset_hold: got %h expected 0", obs);
    end
    @(negedge clk);
    rst_n = 1'b1;
    mem_ready = 1'b0;
    #1;
    checks++;
    if (obs !== outs_t'(0)) begin
      errors++; $display("FAIL reset_start: got %h expected 0", obs);
    end
    @(posedge clk); #1;
    checks++;
    if (obs !== fetch_o(1'b0)) begin
      errors++; $display("FAIL reset_first_fetch: got %h expected %h", obs, fetch_o(1'b0));
    end
  endtask

  task automatic test_r_type();
    test_instr("r_type", RTYP, 0, 0, 1'b0);
  endtask

  task automatic test_load_wait();
    test_instr("load_wait3", LOAD, 0, 3, 1'b0);
  endtask

  task automatic test_branches();
    test_instr("branch_not_taken", BR, 0, 0, 1'b0);
    test_instr("branch_taken", BR, 0, 0, 1'b1);
  endtask

  task automatic test_jalr();
    test_instr("jalr", JALR, 0, 0, 1'b0);
    test_instr("jal", JAL, 1, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 40; n++) begin
      test_instr($sformatf("random_%0d", n), legal_ops[$urandom_range(8, 0)],
                 int'($urandom_range(2, 0)), int'($urandom_range(2, 0)), rnd());
    end
  endtask

  task automatic test_reset_mid_store();
    outs_t got;
    op = STORE;
    build_trace(STORE, 0, 2, 1'b0);
    // FETCH, DECODE, MEM_ADR, first MEM_WRITE wait cycle
    for (int k = 0; k < 4; k++) begin
      drive_cycle(trace[k].rdy, trace[k].bt, got);
      checks++;
      if (got !== trace[k].exp) begin
        errors++;
        $display("FAIL mid_store cycle %0d: got %h expected %h", k, got, trace[k].exp);
      end
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== outs_t'(0)) begin
      errors++; $display("FAIL mid_store_reset_async: got %h expected 0", obs);
    end
    @(negedge clk);
    rst_n = 1'b1;
    mem_ready = 1'b0;
    #1;
    checks++;
    if (obs !== outs_t'(0)) begin
      errors++; $display("FAIL mid_store_start: got %h expected 0", obs);
    end
    @(posedge clk); #1;
    checks++;
    if (obs !== fetch_o(1'b0)) begin
      errors++; $display("FAIL mid_store_refetch: got %h expected %h", obs, fetch_o(1'b0));
    end
  endtask

  task automatic test_trap();
    test_instr("trap", BAD, 0, 0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== outs_t'(0)) begin
      errors++; $display("FAIL trap_reset_clear: got %h expected 0", obs);
    end
    @(negedge clk);
    rst_n = 1'b1;
    mem_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (obs !== fetch_o(1'b1)) begin
      errors++; $display("FAIL trap_refetch: got %h expected %h", obs, fetch_o(1'b1));
    end
  endtask

  initial begin
    test_reset();
    test_r_type();
    test_load_wait();
    test_branches();
    test_jalr();
    test_back_to_back();
    test_reset_mid_store();
    test_trap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
